// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment reader: active-low glyph patterns (bit6=g .. bit0=a),
// digit width and FSM state encoding.
package seg7_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_pattern_encoder.sv
// Combinational inverse of a BCD->7seg decoder: active-low pattern -> value/decodable/blank.
// SEG7_READER_HEX_EN additionally accepts the A..F glyphs as values 10..15.
module seg7_pattern_encoder
    import seg7_pkg::*;
(
    input  logic [6:0]         pattern_i,
    output logic [DIGIT_W-1:0] value_o,
    output logic               decodable_o,
    output logic               blank_o
);

    always_comb begin
        value_o     = '0;
        decodable_o = 1'b1;
        blank_o     = 1'b0;
        case (pattern_i)
            SEG_0: value_o = 4'd0;
            SEG_1: value_o = 4'd1;
            SEG_2: value_o = 4'd2;
            SEG_3: value_o = 4'd3;
            SEG_4: value_o = 4'd4;
            SEG_5: value_o = 4'd5;
            SEG_6: value_o = 4'd6;
            SEG_7: value_o = 4'd7;
            SEG_8: value_o = 4'd8;
            SEG_9: value_o = 4'd9;
`ifdef SEG7_READER_HEX_EN
            SEG_A: value_o = 4'd10;
            SEG_B: value_o = 4'd11;
            SEG_C: value_o = 4'd12;
            SEG_D: value_o = 4'd13;
            SEG_E: value_o = 4'd14;
            SEG_F: value_o = 4'd15;
`endif
            SEG_BLANK: begin
                decodable_o = 1'b0;
                blank_o     = 1'b1;
            end
            default: decodable_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Recovers per-digit values from a scanned active-low 7-segment bus with synchronisation
// and stability filtering. SEG7_READER_HEX_EN enables hex glyph decoding in the encoder.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS    = 4,
    parameter  int STABLE_CYCLES = 8,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [6:0]                    seg_n,
    input  logic [NUM_DIGITS-1:0]         an_n,
    input  logic                          clr,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]         dig_valid,
    output logic                          upd,
    output logic [IDX_W-1:0]              upd_idx,
    output logic                          err
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int LOWS_W = $clog2(NUM_DIGITS + 1);

    logic [6:0]            seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;

    state_e                state_q, state_d;
    logic [6:0]            lat_seg_q, lat_seg_d;
    logic [IDX_W-1:0]      lat_idx_q, lat_idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  upd_q, upd_d;
    logic [IDX_W-1:0]      upd_idx_q, upd_idx_d;
    logic                  err_q, err_d;

    logic [LOWS_W-1:0]     low_cnt;
    logic [IDX_W-1:0]      an_idx;
    logic                  sample_valid;
    logic                  same;
    logic                  commit;

    logic [DIGIT_W-1:0]    enc_value;
    logic                  enc_dec;
    logic                  enc_blank;

    // Synchronisers reset to the blank display so nothing is mistaken for a sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            an_s1_q  <= '1;
            an_s2_q  <= '1;
        end else begin
            seg_s1_q <= seg_n;
            seg_s2_q <= seg_s1_q;
            an_s1_q  <= an_n;
            an_s2_q  <= an_s1_q;
        end
    end

    always_comb begin
        low_cnt = '0;
        an_idx  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s2_q[i]) begin
                low_cnt = low_cnt + LOWS_W'(1);
                an_idx  = IDX_W'(i);
            end
        end
    end

    assign sample_valid = (low_cnt == LOWS_W'(1));
    assign same = sample_valid && (seg_s2_q == lat_seg_q) && (an_idx == lat_idx_q);

    seg7_pattern_encoder u_enc (
        .pattern_i   (seg_s2_q),
        .value_o     (enc_value),
        .decodable_o (enc_dec),
        .blank_o     (enc_blank)
    );

    always_comb begin
        state_d   = state_q;
        lat_seg_d = lat_seg_q;
        lat_idx_d = lat_idx_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        if (!sample_valid) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if ((state_q == SETTLE) && same) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!((state_q == HOLD) && same)) begin
            state_d   = SETTLE;
            lat_seg_d = seg_s2_q;
            lat_idx_d = an_idx;
            cnt_d     = CNT_W'(1);
        end
        // The commit happens on the cycle the count reaches the threshold, not one later.
        if ((state_d == SETTLE) && (cnt_d == CNT_W'(STABLE_CYCLES))) begin
            commit  = 1'b1;
            state_d = HOLD;
        end
    end

    always_comb begin
        upd_d     = commit;
        upd_idx_d = commit ? an_idx : '0;
        err_d     = clr ? 1'b0 : err_q;
        if (commit && !enc_dec && !enc_blank) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_seg_q <= '1;
            lat_idx_q <= '0;
            cnt_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_seg_q <= lat_seg_d;
            lat_idx_q <= lat_idx_d;
            cnt_q     <= cnt_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            err_q     <= err_d;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [DIGIT_W-1:0] val_q;
        logic               vld_q;
        logic               wr;

        assign wr = commit && (an_idx == IDX_W'(gi));

        // Blank and invalid commits drop the valid bit but keep the last value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                val_q <= '0;
                vld_q <= 1'b0;
            end else if (wr) begin
                vld_q <= enc_dec;
                if (enc_dec) begin
                    val_q <= enc_value;
                end
            end
        end

        assign digits[gi*DIGIT_W +: DIGIT_W] = val_q;
        assign dig_valid[gi]                 = vld_q;
    end

    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;
    assign err     = err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed scenarios plus randomized scanning,
// checked each cycle against a run-length reference model of the display reader.
module tb_seg7_reader;

    localparam int N = 4;
    localparam int S = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   seg_n;
    logic [N-1:0] an_n;
    logic         clr;
    logic [4*N-1:0] digits;
    logic [N-1:0] dig_valid;
    logic         upd;
    logic [1:0]   upd_idx;
    logic         err;

    seg7_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .clr       (clr),
        .digits    (digits),
        .dig_valid (dig_valid),
        .upd       (upd),
        .upd_idx   (upd_idx),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`ifdef SEG7_READER_HEX_EN
    localparam int MAX_VAL = 15;
`else
    localparam int MAX_VAL = 9;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: input history, run length of identical valid samples, register file.
    logic [6:0]   m_s1_seg, m_s2_seg, m_pseg;
    logic [N-1:0] m_s1_an, m_s2_an, m_pan;
    bit           m_pv;
    int           m_run;
    int           m_val [N];
    logic [N-1:0] m_dv;
    bit           m_err, m_upd;
    int           m_idx;
    int           upd_seen;
    int           first_upd;
    int           cyc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [6:0] p, output int v);
        v = 0;
        for (int k = 0; k <= MAX_VAL; k++) begin
            if (glyph[k] == p) begin
                v = k;
                return 0;
            end
        end
        if (p == 7'h7f) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_s1_seg = '1; m_s2_seg = '1; m_s1_an = '1; m_s2_an = '1;
        m_pseg = '1; m_pan = '1; m_pv = 0; m_run = 0;
        for (int k = 0; k < N; k++) m_val[k] = 0;
        m_dv = '0; m_err = 0; m_upd = 0; m_idx = 0;
    endtask

    task automatic model_edge();
        int lows, idx, val, kind;
        bit v;
        lows = 0; idx = 0;
        for (int k = 0; k < N; k++) if (!m_s2_an[k]) begin lows++; idx = k; end
        v = (lows == 1);
        if (!v) m_run = 0;
        else if (m_pv && m_s2_seg == m_pseg && m_s2_an == m_pan) begin
            if (m_run <= S) m_run++;
        end else m_run = 1;
        m_pv = v; m_pseg = m_s2_seg; m_pan = m_s2_an;
        m_upd = 0;
        if (clr) m_err = 0;
        if (v && m_run == S) begin
            m_upd = 1;
            m_idx = idx;
            kind  = classify(m_s2_seg, val);
            if (kind == 0) begin m_val[idx] = val; m_dv[idx] = 1'b1; end
            else begin
                m_dv[idx] = 1'b0;
                if (kind == 2) m_err = 1;
            end
        end
        m_s2_seg = m_s1_seg; m_s2_an = m_s1_an;
        m_s1_seg = seg_n;    m_s1_an = an_n;
    endtask

    task automatic compare_all();
        logic [4*N-1:0] exp_d;
        for (int k = 0; k < N; k++) exp_d[4*k +: 4] = 4'(m_val[k]);
        check("upd", 32'(upd), 32'(m_upd));
        if (m_upd) check("upd_idx", 32'(upd_idx), 32'(m_idx));
        check("digits", 32'(digits), 32'(exp_d));
        check("dig_valid", 32'(dig_valid), 32'(m_dv));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic cycle(input logic [6:0] s, input logic [N-1:0] a, input logic c);
        seg_n = s; an_n = a; clr = c;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        compare_all();
        if (upd === 1'b1) begin
            upd_seen++;
            if (first_upd < 0) first_upd = cyc;
        end
    endtask

    task automatic async_reset(input string tag);
        #1 rst = 1'b1;
        #1;
        check({tag, "_digits"}, 32'(digits), 32'h0);
        check({tag, "_valid"}, 32'(dig_valid), 32'h0);
        check({tag, "_upd"}, 32'(upd), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_window();
        upd_seen = 0; first_upd = -1; cyc = 0;
    endtask

    initial begin
        logic [6:0] pat;
        logic [N-1:0] an;
        int d, hold;
        seg_n = '1; an_n = '1; clr = 1'b0; rst = 1'b0;
        model_reset();
        async_reset("rst0");

        // 1: single digit latency
        start_window();
        for (int i = 0; i < 10; i++) cycle(glyph[2], 4'b1110, 1'b0);
        check("t1_latency", 32'(first_upd), 32'd10);
        check("t1_digit0", 32'(digits[3:0]), 32'd2);
        check("t1_valid", 32'(dig_valid), 32'b0001);

        // 2: round-robin scan showing 9,0,7,5
        start_window();
        for (int sc = 0; sc < 2; sc++) begin
            for (int k = 0; k < N; k++) begin
                d = (k == 0) ? 9 : (k == 1) ? 0 : (k == 2) ? 7 : 5;
                an = ~(N'(1) << k);
                for (int i = 0; i < 16; i++) cycle(glyph[d], an, 1'b0);
            end
        end
        check("t2_digits", 32'(digits), 32'h5709);
        check("t2_valid", 32'(dig_valid), 32'hf);
        check("t2_upd_count", 32'(upd_seen), 32'd8);

        // 3: glitch of 8 then stable 3 on digit 1
        start_window();
        for (int i = 0; i < 5; i++) cycle(glyph[8], 4'b1101, 1'b0);
        for (int i = 0; i < 12; i++) cycle(glyph[3], 4'b1101, 1'b0);
        check("t3_upd_count", 32'(upd_seen), 32'd1);
        check("t3_digit1", 32'(digits[7:4]), 32'd3);

        // 4: 'A' glyph on digit 2
        for (int i = 0; i < 12; i++) cycle(glyph[10], 4'b1011, 1'b0);
`ifdef SEG7_READER_HEX_EN
        check("t4_digit2", 32'(digits[11:8]), 32'd10);
        check("t4_err", 32'(err), 32'd0);
        check("t4_valid2", 32'(dig_valid[2]), 32'd1);
`else
        check("t4_digit2", 32'(digits[11:8]), 32'd7);
        check("t4_err", 32'(err), 32'd1);
        check("t4_valid2", 32'(dig_valid[2]), 32'd0);
`endif
        cycle(glyph[10], 4'b1011, 1'b1);
        check("t4_clr", 32'(err), 32'd0);

        // 5: two anodes low, then none
        start_window();
        for (int i = 0; i < 50; i++) cycle(glyph[1], 4'b1100, 1'b0);
        for (int i = 0; i < 50; i++) cycle(glyph[1], 4'b1111, 1'b0);
        check("t5_upd_count", 32'(upd_seen), 32'd0);
        check("t5_err", 32'(err), 32'd0);

        // 6: reset mid-settle, then full re-acquisition
        for (int i = 0; i < 7; i++) cycle(glyph[2], 4'b1110, 1'b0);
        async_reset("t6_rst");
        start_window();
        for (int i = 0; i < 12; i++) cycle(glyph[2], 4'b1110, 1'b0);
        check("t6_latency", 32'(first_upd), 32'd10);
        check("t6_digit0", 32'(digits[3:0]), 32'd2);

        // Random scanning with glitches, blanks, garbage and bad anodes
        for (int t = 0; t < 400; t++) begin
            d = $urandom_range(0, N - 1);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: pat = glyph[$urandom_range(0, 15)];
                6:                pat = 7'h7f;
                7:                pat = 7'($urandom);
                default:          pat = glyph[$urandom_range(0, 9)];
            endcase
            an = ($urandom_range(0, 9) == 0) ? N'($urandom) : ~(N'(1) << d);
            hold = $urandom_range(1, 20);
            for (int i = 0; i < hold; i++)
                cycle(pat, an, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
